// File: rtl/fifo_stream_writer.sv
// Valid/ready stream to FIFO write port: packs {last, data}, decouples fifo_full through a 2-entry skid buffer.
// Writes are held off for WARMUP cycles after reset; optional FIFO_WR_STAT_EN builds the frame_cnt counter.
module fifo_stream_writer #(
    parameter int DSIZE  = 127,
    parameter int WARMUP = 10
) (
    input  logic             wr_clk,
    input  logic             wr_rst_Q,
    input  logic [DSIZE-1:0] s_data,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [DSIZE:0]   fifo_din,
    output logic             fifo_wr_en,
    input  logic             fifo_full,
    output logic             in_frame
`ifdef FIFO_WR_STAT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    typedef enum logic [1:0] {WARM, IDLE, FRAME} state_t;

    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    state_t           state, state_nxt;
    logic [7:0]       warm_cnt;
    logic [DSIZE:0]   head_q, head_nxt;
    logic [DSIZE:0]   skid_q, skid_nxt;
    logic             head_vld, head_vld_nxt;
    logic             skid_vld, skid_vld_nxt;
    logic             accept;
    logic             drain;

    assign accept     = s_valid && s_ready;
    assign drain      = head_vld && !fifo_full;
    assign fifo_wr_en = drain;
    assign fifo_din   = head_q;
    assign in_frame   = (state == FRAME);

    always_ff @(posedge wr_clk or posedge wr_rst_Q) begin
        if (wr_rst_Q) begin
            state <= WARM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WARM:    if (warm_cnt == WARM_LAST) state_nxt = IDLE;
            IDLE:    if (accept && !s_last)     state_nxt = FRAME;
            FRAME:   if (accept && s_last)      state_nxt = IDLE;
            default: state_nxt = WARM;
        endcase
    end

    always_ff @(posedge wr_clk or posedge wr_rst_Q) begin
        if (wr_rst_Q) begin
            warm_cnt <= '0;
        end else if (state == WARM && warm_cnt != WARM_LAST) begin
            warm_cnt <= warm_cnt + 8'd1;
        end
    end

    // Drain first, then place the new beat: it lands in head whenever head is free after the drain.
    always_comb begin
        head_nxt     = head_q;
        head_vld_nxt = head_vld;
        skid_nxt     = skid_q;
        skid_vld_nxt = skid_vld;
        if (drain) begin
            if (skid_vld) begin
                head_nxt     = skid_q;
                head_vld_nxt = 1'b1;
                skid_vld_nxt = 1'b0;
            end else begin
                head_vld_nxt = 1'b0;
            end
        end
        if (accept) begin
            if (!head_vld_nxt) begin
                head_nxt     = {s_last, s_data};
                head_vld_nxt = 1'b1;
            end else begin
                skid_nxt     = {s_last, s_data};
                skid_vld_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst_Q) begin
        if (wr_rst_Q) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
            s_ready  <= 1'b0;
        end else begin
            head_q   <= head_nxt;
            skid_q   <= skid_nxt;
            head_vld <= head_vld_nxt;
            skid_vld <= skid_vld_nxt;
            // Uses the pre-edge state so ready rises one edge after leaving WARM.
            s_ready  <= (state != WARM) && !skid_vld_nxt;
        end
    end

`ifdef FIFO_WR_STAT_EN
    always_ff @(posedge wr_clk or posedge wr_rst_Q) begin
        if (wr_rst_Q) begin
            frame_cnt <= '0;
        end else if (drain && head_q[DSIZE]) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
